jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller: the slave-side consumer of the tester-driven JTAG pins (tdi, tms), producing tdo.
- Holds the 16-state TAP FSM, instruction register, BYPASS, IDCODE and one USER data register.
- Exports capture/shift/update strobes and a select to the downstream boundary-scan chain around the pad groups.

---
 rtl/jtag_pkg.sv | 33 +++
 rtl/jtag_tap_ctrl_if.sv | 35 +++
 rtl/jtag_tap_fsm.sv | 50 +++++
 rtl/jtag_tap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_pkg.sv
// JTAG TAP shared definitions: controller states,
// instruction opcodes and IR capture pattern.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PA_DR  = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PA_IR  = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_e;

    localparam logic [3:0] OPC_EXTEST = 4'b0000;
    localparam logic [3:0] OPC_IDCODE = 4'b0001;
    localparam logic [3:0] OPC_SAMPLE = 4'b0010;
    localparam logic [3:0] OPC_USER   = 4'b1000;
    localparam logic [3:0] OPC_BYPASS = 4'b1111;

    // Low two bits captured into the IR shift stage.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Pin-side and boundary-chain signals of the TAP
// controller, grouped so tester and TAP see one bundle.
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH      = 4,
    parameter int USER_DR_WIDTH = 16
);

    logic                     tdi;
    logic                     tms;
    logic                     tdo;
    logic                     tdo_en;
    logic                     bsr_sel;
    logic                     bsr_tdo;
    logic                     capture_dr;
    logic                     shift_dr;
    logic                     update_dr;
    logic                     extest;
    logic [USER_DR_WIDTH-1:0] user_dr_q;
    logic [IR_WIDTH-1:0]      ir_q;

    modport slave (
        input  tdi, tms, bsr_tdo,
        output tdo, tdo_en, bsr_sel,
        output capture_dr, shift_dr, update_dr,
        output extest, user_dr_q, ir_q
    );

    modport master (
        output tdi, tms, bsr_tdo,
        input  tdo, tdo_en, bsr_sel,
        input  capture_dr, shift_dr, update_dr,
        input  extest, user_dr_q, ir_q
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine, advanced
// on the rising edge of tck by tms.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    // Next-state decode of the standard TAP graph.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tms ? TLR    : RTI;
            RTI:    state_d = tms ? SEL_DR : RTI;
            SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tms ? EX1_DR : SH_DR;
            SH_DR:  state_d = tms ? EX1_DR : SH_DR;
            EX1_DR: state_d = tms ? UPD_DR : PA_DR;
            PA_DR:  state_d = tms ? EX2_DR : PA_DR;
            EX2_DR: state_d = tms ? UPD_DR : SH_DR;
            UPD_DR: state_d = tms ? SEL_DR : RTI;
            SEL_IR: state_d = tms ? TLR    : CAP_IR;
            CAP_IR: state_d = tms ? EX1_IR : SH_IR;
            SH_IR:  state_d = tms ? EX1_IR : SH_IR;
            EX1_IR: state_d = tms ? UPD_IR : PA_IR;
            PA_IR:  state_d = tms ? EX2_IR : PA_IR;
            EX2_IR: state_d = tms ? UPD_IR : SH_IR;
            UPD_IR: state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // State register, forced to Test-Logic-Reset by trst.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, BYPASS/IDCODE/USER data
// registers, tdo mux and falling-edge output stage.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int          IR_WIDTH      = 4,
    parameter logic [31:0] IDCODE_VAL    = 32'h1AB3_C0F1,
    parameter int          USER_DR_WIDTH = 16
) (
    input  logic           tck,
    input  logic           trst,
    jtag_tap_ctrl_if.slave jtag
);

    localparam logic [IR_WIDTH-1:0] OP_EXT =
        IR_WIDTH'(OPC_EXTEST);
    localparam logic [IR_WIDTH-1:0] OP_IDC =
        IR_WIDTH'(OPC_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_SMP =
        IR_WIDTH'(OPC_SAMPLE);
    localparam logic [IR_WIDTH-1:0] OP_USR =
        IR_WIDTH'(OPC_USER);
    localparam logic [IR_WIDTH-1:0] OP_BYP =
        IR_WIDTH'(OPC_BYPASS);
    localparam logic [IR_WIDTH-1:0] IR_CAP =
        {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE};

    localparam int UW = USER_DR_WIDTH;

    tap_state_e state;

    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                byp_q, byp_d;
    logic [31:0]         idc_q, idc_d;
    logic [UW-1:0]       usr_sr_q, usr_sr_d;
    logic [UW-1:0]       user_dr_q, user_dr_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic sel_ext, sel_smp, sel_idc, sel_usr, sel_byp;
    logic sel_bsr;

    jtag_tap_fsm u_fsm (
        .tck     (tck),
        .trst    (trst),
        .tms     (jtag.tms),
        .state_o (state)
    );

    // Instruction decode; unknown opcodes act as BYPASS.
    always_comb begin
        sel_ext = 1'b0;
        sel_smp = 1'b0;
        sel_idc = 1'b0;
        sel_usr = 1'b0;
        sel_byp = 1'b0;
        unique case (1'b1)
            (ir_q == OP_EXT): sel_ext = 1'b1;
            (ir_q == OP_SMP): sel_smp = 1'b1;
            (ir_q == OP_IDC): sel_idc = 1'b1;
            (ir_q == OP_USR): sel_usr = 1'b1;
            (ir_q == OP_BYP): sel_byp = 1'b1;
            default:          sel_byp = 1'b1;
        endcase
    end

    assign sel_bsr = sel_ext | sel_smp;

    // IR shift stage: capture pattern, then LSB-first shift.
    always_comb begin
        ir_sr_d = ir_sr_q;
        if (state == CAP_IR) begin
            ir_sr_d = IR_CAP;
        end else if (state == SH_IR) begin
            ir_sr_d = {jtag.tdi, ir_sr_q[IR_WIDTH-1:1]};
        end
    end

    // Internal DR shift stages; only the selected one moves.
    always_comb begin
        byp_d    = byp_q;
        idc_d    = idc_q;
        usr_sr_d = usr_sr_q;
        if (state == CAP_DR) begin
            if (sel_byp) byp_d    = 1'b0;
            if (sel_idc) idc_d    = IDCODE_VAL;
            if (sel_usr) usr_sr_d = user_dr_q;
        end else if (state == SH_DR) begin
            if (sel_byp) byp_d    = jtag.tdi;
            if (sel_idc) idc_d    = {jtag.tdi, idc_q[31:1]};
            if (sel_usr) usr_sr_d = {jtag.tdi, usr_sr_q[UW-1:1]};
        end
    end

    // Rising-edge shift registers.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr_q  <= '0;
            byp_q    <= 1'b0;
            idc_q    <= '0;
            usr_sr_q <= '0;
        end else begin
            ir_sr_q  <= ir_sr_d;
            byp_q    <= byp_d;
            idc_q    <= idc_d;
            usr_sr_q <= usr_sr_d;
        end
    end

    // Update stages and tdo source for the falling edge.
    always_comb begin
        ir_d      = ir_q;
        user_dr_d = user_dr_q;
        tdo_d     = tdo_q;
        tdo_en_d  = 1'b0;
        if (state == TLR) begin
            ir_d = OP_IDC;
        end else if (state == UPD_IR) begin
            ir_d = ir_sr_q;
        end
        if (state == UPD_DR && sel_usr) begin
            user_dr_d = usr_sr_q;
        end
        if (state == SH_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else if (state == SH_DR) begin
            tdo_en_d = 1'b1;
            unique case (1'b1)
                sel_bsr: tdo_d = jtag.bsr_tdo;
                sel_idc: tdo_d = idc_q[0];
                sel_usr: tdo_d = usr_sr_q[0];
                default: tdo_d = byp_q;
            endcase
        end
    end

    // Falling-edge instruction, USER update and tdo registers.
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            ir_q      <= OP_IDC;
            user_dr_q <= '0;
            tdo_q     <= 1'b0;
            tdo_en_q  <= 1'b0;
        end else begin
            ir_q      <= ir_d;
            user_dr_q <= user_dr_d;
            tdo_q     <= tdo_d;
            tdo_en_q  <= tdo_en_d;
        end
    end

    assign jtag.tdo        = tdo_q;
    assign jtag.tdo_en     = tdo_en_q;
    assign jtag.ir_q       = ir_q;
    assign jtag.user_dr_q  = user_dr_q;
    assign jtag.extest     = sel_ext;
    assign jtag.bsr_sel    = sel_bsr;
    assign jtag.capture_dr = (state == CAP_DR);
    assign jtag.shift_dr   = (state == SH_DR);
    assign jtag.update_dr  = (state == UPD_DR);

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE, BYPASS,
// TLR recovery, pause, USER register and EXTEST abort.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    logic tck = 1'b0;
    logic trst;
    int   errs = 0;
    int   checks = 0;

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl dut (
        .tck  (tck),
        .trst (trst),
        .jtag (bus)
    );

    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step(input logic m, input logic d);
        bus.tms = m;
        bus.tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic scan_dr(input int n,
                           input logic [63:0] din,
                           output logic [63:0] dout,
                           output int en);
        dout = '0;
        en = 0;
        step(1'b1, 1'b0);
        en += int'(bus.tdo_en);
        step(1'b0, 1'b0);
        en += int'(bus.tdo_en);
        step(1'b0, 1'b0);
        en += int'(bus.tdo_en);
        for (int i = 0; i < n; i++) begin
            dout[i] = bus.tdo;
            step(i == n - 1, din[i]);
            en += int'(bus.tdo_en);
        end
        step(1'b1, 1'b0);
        en += int'(bus.tdo_en);
        step(1'b0, 1'b0);
        en += int'(bus.tdo_en);
    endtask

    task automatic scan_ir(input logic [3:0] din,
                           output logic [3:0] dout);
        dout = '0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            dout[i] = bus.tdo;
            step(i == 3, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        trst = 1'b1;
        bus.tms = 1'b1;
        bus.tdi = 1'b0;
        bus.bsr_tdo = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        checks++;
        if (bus.ir_q !== 4'b0001) begin
            errs++;
            $display("FAIL rst_ir: got %b want 0001", bus.ir_q);
        end
        checks++;
        if (bus.user_dr_q !== 16'h0000) begin
            errs++;
            $display("FAIL rst_user: got %h want 0000",
                     bus.user_dr_q);
        end
        checks++;
        if (bus.tdo !== 1'b0 || bus.tdo_en !== 1'b0) begin
            errs++;
            $display("FAIL rst_tdo: got %b/%b want 0/0",
                     bus.tdo, bus.tdo_en);
        end
        trst = 1'b0;
        step(1'b0, 1'b0);
        checks++;
        if (bus.ir_q !== 4'b0001 || bus.tdo_en !== 1'b0) begin
            errs++;
            $display("FAIL rti_ir: got %b/%b want 0001/0",
                     bus.ir_q, bus.tdo_en);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bus.capture_dr !== 1'b1) begin
            errs++;
            $display("FAIL cap_strobe: got %b want 1",
                     bus.capture_dr);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (bus.update_dr !== 1'b1) begin
            errs++;
            $display("FAIL upd_strobe: got %b want 1",
                     bus.update_dr);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_idcode();
        logic [63:0] d;
        int en;
        scan_dr(32, 64'h0, d, en);
        checks++;
        if (d[31:0] !== 32'h1AB3_C0F1) begin
            errs++;
            $display("FAIL idcode: got %h want 1ab3c0f1",
                     d[31:0]);
        end
        checks++;
        if (en !== 32) begin
            errs++;
            $display("FAIL idcode_en: got %0d want 32", en);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        logic [3:0]  o;
        int en;
        scan_ir(4'b1111, o);
        checks++;
        if (o !== 4'b0001) begin
            errs++;
            $display("FAIL ir_capture: got %b want 0001", o);
        end
        checks++;
        if (bus.ir_q !== 4'b1111) begin
            errs++;
            $display("FAIL ir_load: got %b want 1111", bus.ir_q);
        end
        scan_dr(8, 64'hB2, d, en);
        checks++;
        if (d[7:0] !== 8'h64) begin
            errs++;
            $display("FAIL bypass: got %h want 64", d[7:0]);
        end
        checks++;
        if (en !== 8) begin
            errs++;
            $display("FAIL bypass_en: got %0d want 8", en);
        end
        scan_ir(4'b0101, o);
        scan_dr(8, 64'hC3, d, en);
        checks++;
        if (d[7:0] !== 8'h86) begin
            errs++;
            $display("FAIL undef_bypass: got %h want 86", d[7:0]);
        end
    endtask

    task automatic test_tlr_all();
        int          plen [16];
        logic [7:0]  pbits [16];
        logic [3:0]  o;
        plen  = '{3, 0, 1, 2, 3, 3, 4, 5,
                  4, 2, 3, 4, 4, 5, 6, 5};
        pbits = '{8'h07, 8'h00, 8'h01, 8'h01,
                  8'h01, 8'h05, 8'h05, 8'h15,
                  8'h0D, 8'h03, 8'h03, 8'h03,
                  8'h0B, 8'h0B, 8'h2B, 8'h1B};
        for (int s = 0; s < 16; s++) begin
            scan_ir(4'b1000, o);
            checks++;
            if (bus.ir_q !== 4'b1000) begin
                errs++;
                $display("FAIL tlr_pre s=%0d: got %b want 1000",
                         s, bus.ir_q);
            end
            for (int k = 0; k < plen[s]; k++) begin
                step(pbits[s][k], 1'b0);
            end
            checks++;
            if (bus.capture_dr !== (s == 3) ||
                bus.shift_dr !== (s == 4) ||
                bus.update_dr !== (s == 8) ||
                bus.tdo_en !== (s == 4 || s == 11)) begin
                errs++;
                $display("FAIL strobes s=%0d: got %b%b%b%b",
                         s, bus.capture_dr, bus.shift_dr,
                         bus.update_dr, bus.tdo_en);
            end
            repeat (5) step(1'b1, 1'b0);
            checks++;
            if (bus.ir_q !== 4'b0001) begin
                errs++;
                $display("FAIL tlr_ir s=%0d: got %b want 0001",
                         s, bus.ir_q);
            end
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            checks++;
            if (bus.capture_dr !== 1'b1) begin
                errs++;
                $display("FAIL tlr_rti s=%0d: got %b want 1",
                         s, bus.capture_dr);
            end
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_pause();
        logic [15:0] din;
        logic [3:0]  o;
        din = 16'h3C96;
        scan_ir(4'b1000, o);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(i == 7, din[i]);
        repeat (3) step(1'b0, 1'b1);
        checks++;
        if (bus.tdo_en !== 1'b0) begin
            errs++;
            $display("FAIL pause_en: got %b want 0", bus.tdo_en);
        end
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 8; i < 16; i++) step(i == 15, din[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bus.user_dr_q !== 16'h3C96) begin
            errs++;
            $display("FAIL pause_user: got %h want 3c96",
                     bus.user_dr_q);
        end
    endtask

    task automatic test_user();
        logic [63:0] d;
        logic [3:0]  o;
        int en;
        scan_ir(4'b1000, o);
        scan_dr(16, 64'hA55A, d, en);
        checks++;
        if (bus.user_dr_q !== 16'hA55A) begin
            errs++;
            $display("FAIL user_upd: got %h want a55a",
                     bus.user_dr_q);
        end
        checks++;
        if (d[15:0] !== 16'h3C96) begin
            errs++;
            $display("FAIL user_prev: got %h want 3c96", d[15:0]);
        end
        scan_dr(16, 64'h0, d, en);
        checks++;
        if (d[15:0] !== 16'hA55A) begin
            errs++;
            $display("FAIL user_read: got %h want a55a", d[15:0]);
        end
        checks++;
        if (bus.user_dr_q !== 16'h0000) begin
            errs++;
            $display("FAIL user_zero: got %h want 0000",
                     bus.user_dr_q);
        end
    endtask

    task automatic test_extest();
        logic [3:0] o;
        logic [5:0] pat;
        pat = 6'b011010;
        scan_ir(4'b0000, o);
        checks++;
        if (bus.extest !== 1'b1 || bus.bsr_sel !== 1'b1) begin
            errs++;
            $display("FAIL extest_sel: got %b/%b want 1/1",
                     bus.extest, bus.bsr_sel);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.bsr_tdo = pat[i];
            step(1'b0, 1'b1);
            checks++;
            if (bus.tdo !== pat[i] || bus.tdo_en !== 1'b1) begin
                errs++;
                $display("FAIL bsr_tdo i=%0d: got %b/%b want %b/1",
                         i, bus.tdo, bus.tdo_en, pat[i]);
            end
        end
        trst = 1'b1;
        #1;
        checks++;
        if (bus.extest !== 1'b0 || bus.tdo_en !== 1'b0 ||
            bus.shift_dr !== 1'b0) begin
            errs++;
            $display("FAIL abort: got %b%b%b want 000",
                     bus.extest, bus.tdo_en, bus.shift_dr);
        end
        checks++;
        if (bus.user_dr_q !== 16'h0000 ||
            bus.ir_q !== 4'b0001) begin
            errs++;
            $display("FAIL abort_regs: got %h/%b want 0000/0001",
                     bus.user_dr_q, bus.ir_q);
        end
        @(negedge tck);
        #1;
        trst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_tlr_all();
        test_pause();
        test_user();
        test_extest();
        $display("Result: errors=%0d of %0d checks",
                 errs, checks);
        $finish;
    end

endmodule
